// File: rtl/div_pkg.sv
// Shared definitions for the 8-bit sequential restoring divider.
// Holds operand width, iteration count and the controller state type.
package div_pkg;

    localparam int DIV_W    = 8;
    localparam int DIV_ITER = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sub_8bit.sv
// Trial subtractor: 9-bit minuend minus 8-bit subtrahend, lookahead carries.
// Ports: i_min[8:0], i_sub[7:0] -> o_diff[7:0] (low bits), o_borrow.
module sub_8bit (
    input  logic [8:0] i_min,
    input  logic [7:0] i_sub,
    output logic [7:0] o_diff,
    output logic       o_borrow
);

    logic [8:0] w_nb;
    logic [8:0] w_g;
    logic [8:0] w_p;
    logic [9:0] w_c;
    logic       w_t;

    // Subtract as i_min + ~sub + 1; every carry is expanded directly from
    // generate/propagate terms and the carry-in instead of rippling.
    always_comb begin
        w_nb = ~{1'b0, i_sub};
        w_g  = i_min & w_nb;
        w_p  = i_min ^ w_nb;
        w_c  = '0;
        w_t  = 1'b0;
        w_c[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            w_c[i+1] = w_g[i];
            w_t      = w_p[i];
            for (int j = i - 1; j >= 0; j--) begin
                w_c[i+1] = w_c[i+1] | (w_t & w_g[j]);
                w_t      = w_t & w_p[j];
            end
            w_c[i+1] = w_c[i+1] | w_t;
        end
        o_diff   = w_p[7:0] ^ w_c[7:0];
        o_borrow = ~w_c[9];
    end

endmodule

// File: rtl/seq_div_8bit.sv
// Sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Ports: clk, rst (sync, active-high), Start, A, B in; Q, R, Busy, Done out;
// Err out only when DIV_ZERO_ERR_EN is defined (B=0 short-cut to DONE).
module seq_div_8bit
    import div_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       Start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Q,
    output logic [7:0] R,
    output logic       Busy,
    output logic       Done
`ifdef DIV_ZERO_ERR_EN
    ,
    output logic       Err
`endif
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_cnt;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [7:0] r_rem;
    logic [6:0] r_quo;
    logic [7:0] r_q;
    logic [7:0] r_r;
    logic       w_zero;
    logic       w_last;
    logic [8:0] w_min;
    logic [7:0] w_diff;
    logic       w_borrow;
    logic [7:0] w_rem_nxt;
    logic [7:0] w_quo_nxt;

`ifdef DIV_ZERO_ERR_EN
    logic       r_err;
    assign w_zero = (B == 8'd0);
    assign Err    = r_err;
`else
    assign w_zero = 1'b0;
`endif

    assign w_last = (r_cnt == 3'(DIV_ITER - 1));

    // Partial remainder shifted left with the next dividend bit appended.
    assign w_min = {r_rem, r_a[DIV_W-1]};

    sub_8bit u_sub (
        .i_min    (w_min),
        .i_sub    (r_b),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    // On borrow the shifted value is kept; it is below B so fits 8 bits.
    assign w_rem_nxt = w_borrow ? w_min[7:0] : w_diff;
    assign w_quo_nxt = {r_quo, ~w_borrow};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (Start) begin
                    w_next = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        Busy = (r_state != IDLE);
        Done = (r_state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_b   <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_q   <= '0;
            r_r   <= '0;
`ifdef DIV_ZERO_ERR_EN
            r_err <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (Start) begin
                        r_a   <= A;
                        r_b   <= B;
                        r_rem <= '0;
                        r_quo <= '0;
                        r_cnt <= '0;
`ifdef DIV_ZERO_ERR_EN
                        r_err <= w_zero;
                        if (w_zero) begin
                            r_q <= 8'hFF;
                            r_r <= A;
                        end
`endif
                    end
                end
                RUN: begin
                    r_a   <= {r_a[6:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt[6:0];
                    r_cnt <= r_cnt + 3'd1;
                    // Outputs only change with the final step.
                    if (w_last) begin
                        r_q <= w_quo_nxt;
                        r_r <= w_rem_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Q = r_q;
    assign R = r_r;

endmodule
